// File: rtl/xcorr_pkg.sv
// ---------------------------------------------------------------------------
// xcorr_pkg
// Shared definitions for the cross-correlation scheduler:
//   state_t    - scheduler FSM states
//   lag_offset - lag-zero bin position for a result RAM of 2^addr_width bins;
//                the centre bin of the RAM corresponds to zero lag.
// ---------------------------------------------------------------------------
package xcorr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SCAN   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    // Bin index that represents zero lag: 2^(addr_width-1).
    function automatic int lag_offset(input int addr_width);
        return 1 << (addr_width - 1);
    endfunction

endpackage

// File: rtl/peak_finder.sv
// ---------------------------------------------------------------------------
// peak_finder
// Running arg-max over a stream of unsigned samples.
//   clk, reset_n   - clock, asynchronous active-low reset
//   in_valid       - sample present this cycle
//   in_first       - first sample of a sweep: loads unconditionally
//   in_index       - bin index of the sample
//   in_data        - sample value (unsigned)
//   max_index      - index of the largest sample seen so far
//   max_value      - value of the largest sample seen so far
// Strict greater-than means the earliest index keeps the peak on ties.
// ---------------------------------------------------------------------------
module peak_finder #(
    parameter int IDX_WIDTH  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic [IDX_WIDTH-1:0]  in_index,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [IDX_WIDTH-1:0]  max_index,
    output logic [DATA_WIDTH-1:0] max_value
);

    logic [IDX_WIDTH-1:0]  max_index_reg;
    logic [DATA_WIDTH-1:0] max_value_reg;
    logic                  take_sample;

    assign take_sample = in_valid && (in_first || (in_data > max_value_reg));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_index_reg <= '0;
            max_value_reg <= '0;
        end else if (take_sample) begin
            max_index_reg <= in_index;
            max_value_reg <= in_data;
        end
    end

    assign max_index = max_index_reg;
    assign max_value = max_value_reg;

endmodule

// File: rtl/xcorr_sched.sv
// ---------------------------------------------------------------------------
// xcorr_sched
// Sequences a correlation engine over microphone pairs (0,k), k = 1..NUM_MICS-1,
// for each captured frame, scans the engine's result RAM for the peak bin and
// reports the signed peak lag per pair.
//   clk, reset_n     - clock, asynchronous active-low reset
//   frame_ready      - pulse: capture buffers hold a new frame
//   buf_hold         - high while the frame is being processed
//   xc_start/xc_done - engine start pulse / completion pulse
//   sel_a, sel_b     - engine input buffer selects (a is always the reference)
//   r_addr, r_data   - result RAM read port (data one cycle after address)
//   lag, lag_pair, peak, lag_valid - per-pair result, qualified by lag_valid
//   overrun          - pulse: a frame arrived while busy and was dropped
//   timeout          - pulse: engine did not finish within TIMEOUT cycles
// ---------------------------------------------------------------------------
module xcorr_sched
    import xcorr_pkg::*;
#(
    parameter int NUM_MICS       = 4,
    parameter int OUT_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT        = 65535
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        frame_ready,
    output logic                        buf_hold,
    output logic                        xc_start,
    input  logic                        xc_done,
    output logic [$clog2(NUM_MICS)-1:0] sel_a,
    output logic [$clog2(NUM_MICS)-1:0] sel_b,
    output logic [OUT_ADDR_WIDTH-1:0]   r_addr,
    input  logic [DATA_WIDTH-1:0]       r_data,
    output logic [OUT_ADDR_WIDTH-1:0]   lag,
    output logic [$clog2(NUM_MICS)-1:0] lag_pair,
    output logic                        lag_valid,
    output logic [DATA_WIDTH-1:0]       peak,
    output logic                        overrun,
    output logic                        timeout
);

    localparam int SEL_WIDTH  = $clog2(NUM_MICS);
    localparam int AW         = OUT_ADDR_WIDTH;
    localparam int CNT_WIDTH  = $clog2(TIMEOUT + 1);
    localparam int SCAN_WIDTH = AW + 1;

    // Scan counter runs 0..2^AW: one extra cycle absorbs the RAM read latency.
    localparam logic [SCAN_WIDTH-1:0] SCAN_LAST  = SCAN_WIDTH'(1) << AW;
    localparam logic [CNT_WIDTH-1:0]  WAIT_LIMIT = CNT_WIDTH'(TIMEOUT);
    localparam logic [SEL_WIDTH-1:0]  FIRST_PAIR = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0]  LAST_PAIR  = SEL_WIDTH'(NUM_MICS - 1);
    localparam logic [AW-1:0]         LAG_CENTER = AW'(lag_offset(AW));

    state_t                  state_reg, state_next;
    logic [SEL_WIDTH-1:0]    pair_reg, pair_next;
    logic [CNT_WIDTH-1:0]    wait_cnt_reg;
    logic [SCAN_WIDTH-1:0]   scan_cnt_reg;
    logic [SEL_WIDTH-1:0]    sel_b_reg;
    logic                    overrun_reg;
    logic [AW-1:0]           lag_hold_reg;
    logic [SEL_WIDTH-1:0]    pair_hold_reg;
    logic [DATA_WIDTH-1:0]   peak_hold_reg;

    logic                    wait_expired;
    logic                    pf_valid;
    logic                    pf_first;
    logic [AW-1:0]           pf_in_index;
    logic [AW-1:0]           pf_index;
    logic [DATA_WIDTH-1:0]   pf_value;
    logic [AW-1:0]           lag_calc;

    // A completion arriving on the limit cycle still counts as done.
    assign wait_expired = (state_reg == ST_WAIT) && !xc_done && (wait_cnt_reg == WAIT_LIMIT);

    // ---------------------------------------------------------------
    // Peak search: r_data in scan cycle c belongs to address c-1, so
    // samples are taken for c = 1..2^AW and c = 1 seeds the maximum.
    // ---------------------------------------------------------------
    assign pf_valid    = (state_reg == ST_SCAN) && (scan_cnt_reg != '0);
    assign pf_first    = (scan_cnt_reg == SCAN_WIDTH'(1));
    assign pf_in_index = scan_cnt_reg[AW-1:0] - AW'(1);

    peak_finder #(
        .IDX_WIDTH  (AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_peak_finder (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (pf_valid),
        .in_first  (pf_first),
        .in_index  (pf_in_index),
        .in_data   (r_data),
        .max_index (pf_index),
        .max_value (pf_value)
    );

    // Bin index to signed lag: modular subtraction of the centre bin.
    assign lag_calc = pf_index - LAG_CENTER;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            pair_reg  <= FIRST_PAIR;
        end else begin
            state_reg <= state_next;
            pair_reg  <= pair_next;
        end
    end

    // ---------------------------------------------------------------
    // Counters and result/select holding registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_reg  <= '0;
            scan_cnt_reg  <= '0;
            sel_b_reg     <= '0;
            overrun_reg   <= 1'b0;
            lag_hold_reg  <= '0;
            pair_hold_reg <= '0;
            peak_hold_reg <= '0;
        end else begin
            // Any frame arriving while busy is dropped and flagged next cycle.
            overrun_reg  <= frame_ready && (state_reg != ST_IDLE);
            wait_cnt_reg <= (state_reg == ST_WAIT) ? wait_cnt_reg + CNT_WIDTH'(1) : '0;
            scan_cnt_reg <= (state_reg == ST_SCAN) ? scan_cnt_reg + SCAN_WIDTH'(1) : '0;
            // Select is latched on the way into START and held through SCAN.
            if (state_next == ST_START) begin
                sel_b_reg <= pair_next;
            end
            // Keep the last report visible after the lag_valid pulse.
            if (state_reg == ST_REPORT) begin
                lag_hold_reg  <= lag_calc;
                pair_hold_reg <= pair_reg;
                peak_hold_reg <= pf_value;
            end
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        pair_next  = pair_reg;
        case (state_reg)
            ST_IDLE: begin
                if (frame_ready) begin
                    state_next = ST_START;
                    pair_next  = FIRST_PAIR;
                end
            end
            ST_START: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (xc_done) begin
                    state_next = ST_SCAN;
                end else if (wait_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (scan_cnt_reg == SCAN_LAST) begin
                    state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (pair_reg == LAST_PAIR) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_START;
                    pair_next  = pair_reg + SEL_WIDTH'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    always_comb begin
        buf_hold  = (state_reg != ST_IDLE);
        xc_start  = (state_reg == ST_START);
        lag_valid = (state_reg == ST_REPORT);
        timeout   = wait_expired;
        overrun   = overrun_reg;
        sel_a     = '0;
        sel_b     = sel_b_reg;
        r_addr    = (state_reg == ST_SCAN) ? scan_cnt_reg[AW-1:0] : '0;
        if (state_reg == ST_REPORT) begin
            lag      = lag_calc;
            lag_pair = pair_reg;
            peak     = pf_value;
        end else begin
            lag      = lag_hold_reg;
            lag_pair = pair_hold_reg;
            peak     = peak_hold_reg;
        end
    end

endmodule

// File: tb/tb_xcorr_sched.sv
// ---------------------------------------------------------------------------
// tb_xcorr_sched
// Randomized scoreboard bench for xcorr_sched. Stimulus fills per-pair result
// RAM images, pushes the expected per-pair peak reports (or timeout events)
// into a queue, and a monitor pops and compares whenever the DUT emits
// lag_valid or timeout. A small engine model answers xc_start by loading the
// result RAM image for sel_b and pulsing xc_done after a programmable delay.
// ---------------------------------------------------------------------------
module tb_xcorr_sched;

    localparam int NUM_MICS = 4;
    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int TMO      = 120;
    localparam int NBINS    = 1 << AW;

    localparam int K_REPORT  = 0;
    localparam int K_TIMEOUT = 1;

    typedef struct {
        int kind;
        int lag;
        int peak;
        int pair;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          frame_ready = 1'b0;
    logic          xc_done = 1'b0;
    logic          buf_hold, xc_start, lag_valid, overrun, timeout;
    logic [1:0]    sel_a, sel_b, lag_pair;
    logic [AW-1:0] r_addr, lag;
    logic [DW-1:0] r_data, peak;

    logic [DW-1:0] ram [NBINS];
    logic [DW-1:0] frame_ram [NUM_MICS][NBINS];

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   exp_overrun = 0;
    int   seen_overrun = 0;
    int   done_delay = 10;
    bit   hang_engine = 1'b0;

    always #5 clk = ~clk;

    xcorr_sched #(
        .NUM_MICS       (NUM_MICS),
        .OUT_ADDR_WIDTH (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT        (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_ready (frame_ready),
        .buf_hold    (buf_hold),
        .xc_start    (xc_start),
        .xc_done     (xc_done),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .r_addr      (r_addr),
        .r_data      (r_data),
        .lag         (lag),
        .lag_pair    (lag_pair),
        .lag_valid   (lag_valid),
        .peak        (peak),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    // Result RAM with one-cycle registered read.
    always @(posedge clk) r_data <= ram[r_addr];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {buf_hold, xc_start, lag_valid, overrun, timeout, sel_a, sel_b,
                     r_addr, lag, lag_pair, peak}, 0);
    endtask

    // Reference: peak value is the maximum bin; reported index is the
    // lowest bin holding that value; lag is index minus the centre bin.
    task automatic push_reports(input int first, input int last);
        for (int p = first; p <= last; p++) begin
            int   maxv;
            int   idx;
            exp_t e;
            maxv = 0;
            for (int b = 0; b < NBINS; b++)
                if (int'(frame_ram[p][b]) > maxv) maxv = int'(frame_ram[p][b]);
            idx = -1;
            for (int b = 0; b < NBINS; b++)
                if (idx < 0 && int'(frame_ram[p][b]) == maxv) idx = b;
            e.kind = K_REPORT;
            e.lag  = idx - NBINS / 2;
            e.peak = maxv;
            e.pair = p;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_timeout();
        exp_t e;
        e.kind = K_TIMEOUT;
        e.lag  = 0;
        e.peak = 0;
        e.pair = 0;
        exp_q.push_back(e);
    endtask

    task automatic fill_frame(input int mode);
        for (int p = 0; p < NUM_MICS; p++)
            for (int b = 0; b < NBINS; b++)
                frame_ram[p][b] = (mode == 0) ? DW'($urandom_range(0, 255))
                                              : DW'($urandom_range(250, 255));
    endtask

    task automatic pulse_frame();
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (buf_hold === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_wait: buf_hold still %b after %0d cycles, expected 0", tag, buf_hold, n);
        end
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (xc_start !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL %s_start_wait: xc_start %b after %0d cycles, expected 1", tag, xc_start, n);
        end
    endtask

    task automatic run_frame(input int delay, input string tag);
        done_delay  = delay;
        hang_engine = 1'b0;
        push_reports(1, NUM_MICS - 1);
        pulse_frame();
        wait_idle(tag);
        repeat (2) @(negedge clk);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    // Engine model.
    initial begin : engine
        int pair;
        bit aborted;
        forever begin
            @(negedge clk);
            if (reset_n && xc_start === 1'b1) begin
                check("sel_a_ref", sel_a, 0);
                pair = int'(sel_b);
                for (int b = 0; b < NBINS; b++) ram[b] = frame_ram[pair][b];
                if (!hang_engine) begin
                    aborted = 1'b0;
                    for (int i = 1; i < done_delay && !aborted; i++) begin
                        @(negedge clk);
                        if (!reset_n) aborted = 1'b1;
                    end
                    if (!aborted) begin
                        xc_done = 1'b1;
                        @(negedge clk);
                        xc_done = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (overrun === 1'b1) seen_overrun++;
            if (lag_valid === 1'b1 || timeout === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: lag_valid=%b timeout=%b, expected no event", lag_valid, timeout);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_kind", {lag_valid, timeout},
                          (mon_e.kind == K_REPORT) ? 2'b10 : 2'b01);
                    if (mon_e.kind == K_REPORT) begin
                        $display("report pair=%0d lag=%0d peak=0x%02h", lag_pair, $signed(lag), peak);
                        check("lag", $signed(lag), mon_e.lag);
                        check("peak", peak, mon_e.peak);
                        check("lag_pair", lag_pair, mon_e.pair);
                    end else begin
                        $display("timeout event");
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int  n;
        bit  restarted;
        for (int b = 0; b < NBINS; b++) ram[b] = '0;

        // Reset state.
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        // Single peak at bin 140 for every pair, engine latency 100.
        for (int p = 0; p < NUM_MICS; p++)
            for (int b = 0; b < NBINS; b++)
                frame_ram[p][b] = (b == 140) ? 8'hF0 : 8'h10;
        run_frame(100, "single_peak");

        // Tie between bins 40 and 90: lowest index must win.
        for (int p = 0; p < NUM_MICS; p++) begin
            for (int b = 0; b < NBINS; b++) frame_ram[p][b] = DW'($urandom_range(0, 254));
            frame_ram[p][40] = 8'hFF;
            frame_ram[p][90] = 8'hFF;
        end
        run_frame(int'($urandom_range(5, 40)), "tie");

        // Random frames, alternating wide and tie-heavy value ranges.
        for (int i = 0; i < 6; i++) begin
            fill_frame(i % 2);
            run_frame(int'($urandom_range(1, 110)), "random");
        end

        // Peak in the last and first bins.
        for (int p = 0; p < NUM_MICS; p++)
            for (int b = 0; b < NBINS; b++)
                frame_ram[p][b] = (b == ((p == 2) ? 0 : NBINS - 1)) ? 8'h80 : 8'h01;
        run_frame(3, "edge_bins");

        // frame_ready during SCAN: overrun next cycle, frame unaffected.
        fill_frame(0);
        done_delay  = 20;
        hang_engine = 1'b0;
        push_reports(1, NUM_MICS - 1);
        pulse_frame();
        n = 0;
        while (r_addr !== 8'd50 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("scan_reached", n < 1000, 1);
        frame_ready = 1'b1;
        exp_overrun++;
        @(negedge clk);
        frame_ready = 1'b0;
        check("overrun_next_cycle", overrun, 1);
        check("overrun_keeps_hold", buf_hold, 1);
        wait_idle("overrun");
        repeat (2) @(negedge clk);
        check("overrun_drained", exp_q.size(), 0);

        // Engine never completes: timeout on WAIT cycle TMO+1.
        fill_frame(0);
        hang_engine = 1'b1;
        push_timeout();
        pulse_frame();
        wait_start("timeout");
        n = 0;
        while (timeout !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_wait_cycles", n, TMO + 1);
        @(negedge clk);
        check("timeout_buf_hold", buf_hold, 0);
        repeat (3) @(negedge clk);
        check("timeout_drained", exp_q.size(), 0);

        // frame_ready in the timeout cycle: overrun, frame not accepted.
        push_timeout();
        pulse_frame();
        wait_start("tmo_frame");
        n = 0;
        while (timeout !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("tmo_frame_cycles", n, TMO + 1);
        frame_ready = 1'b1;
        exp_overrun++;
        @(negedge clk);
        frame_ready = 1'b0;
        check("tmo_frame_overrun", overrun, 1);
        check("tmo_frame_hold", buf_hold, 0);
        restarted = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (xc_start !== 1'b0 || buf_hold !== 1'b0) restarted = 1'b1;
        end
        check("tmo_frame_not_accepted", restarted, 0);
        check("tmo_frame_drained", exp_q.size(), 0);
        hang_engine = 1'b0;

        // Reset during WAIT of pair 2: only pair 1 reported.
        fill_frame(0);
        done_delay = 30;
        push_reports(1, 1);
        pulse_frame();
        wait_start("rst_p1");
        @(negedge clk);
        wait_start("rst_p2");
        repeat (10) @(negedge clk);
        check("rst_sel_b_pair2", sel_b, 2);
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_wait");
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_drained", exp_q.size(), 0);
        fill_frame(1);
        run_frame(50, "after_reset");

        repeat (3) @(negedge clk);
        check("overrun_count", seen_overrun, exp_overrun);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
